// File: rtl/mdu_div_responder_if.sv
// mdu_div_responder_if -- request/response bundle between the EX-stage
// pipeline (master) and the iterative divider (slave).
//   start, signed_op, dividend, divisor, cancel : pipeline -> divider
//   busy, valid, quotient, remainder, result    : divider -> pipeline
interface mdu_div_responder_if #(parameter int WIDTH = 32);
  logic               start;
  logic               signed_op;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               cancel;
  logic               busy;
  logic               valid;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_op, dividend, divisor, cancel,
    input  busy, valid, quotient, remainder, result
  );

  modport slave (
    input  start, signed_op, dividend, divisor, cancel,
    output busy, valid, quotient, remainder, result
  );
endinterface

// File: rtl/mdu_div_responder.sv
// mdu_div_responder -- iterative radix-2 restoring divider answering DIV/DIVU.
// One quotient bit per cycle on operand magnitudes, then a sign fix-up cycle,
// then a one-cycle valid strobe carrying {HI=remainder, LO=quotient}.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : mdu_div_responder_if.slave
//          start/signed_op/dividend/divisor/cancel in,
//          busy/valid/quotient/remainder/result out
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, a divide by zero
// or |dividend| < |divisor| is answered straight from the start edge.
module mdu_div_responder #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mdu_div_responder_if.slave    bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;     // raw dividend, returned on divide by zero
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;

  logic             accept;
  logic             early;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] fix_q, fix_r;

  // Start is only honoured when not busy; a concurrent cancel drops it.
  assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start && !bus.cancel;

  // Unsigned magnitudes: |most-negative| stays exact as a WIDTH-bit value.
  assign a_mag = (bus.signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign b_mag = (bus.signed_op && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

`ifdef DIV_EARLY_OUT_EN
  assign early = (b_mag == '0) || (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // One restoring step: the extra top bit of diff is the borrow.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  // Divide by zero overrides the sign fix-up entirely.
  assign fix_q = dz_q ? '1    : (negq_q ? -quo_q : quo_q);
  assign fix_r = dz_q ? dvd_q : (negr_q ? -rem_q : rem_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    qout_d  = qout_q;
    rout_d  = rout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          dvd_d   = bus.dividend;
          negq_d  = bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          negr_d  = bus.signed_op & bus.dividend[WIDTH-1];
          dz_d    = (bus.divisor == '0);
          state_d = S_CALC;
          if (early) begin
            // Answer is known without iterating.
            qout_d  = (bus.divisor == '0) ? '1 : '0;
            rout_d  = bus.dividend;
            state_d = S_DONE;
          end
        end
      end
      S_CALC: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        qout_d  = fix_q;
        rout_d  = fix_r;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a pending result write.
    if (bus.cancel) begin
      state_d = S_IDLE;
      qout_d  = qout_q;
      rout_d  = rout_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
    end
  end

  assign bus.busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.valid     = (state_q == S_DONE);
  assign bus.quotient  = qout_q;
  assign bus.remainder = rout_q;
  assign bus.result    = {rout_q, qout_q};

endmodule

// File: doc/mdu_div_responder.md
Name: mdu_div_responder

Overview:
- Iterative radix-2 restoring divider for the EX-stage multiply/divide path; it answers DIV/DIVU requests issued by the pipeline.
- Accepts one request per start pulse and computes quotient and remainder over multiple cycles.
- Returns {HI=remainder, LO=quotient} with a one-cycle valid pulse for the HILO write.
- Stall control holds the pipeline on busy; a flush aborts via cancel.

Parameters:
WIDTH, 32, operand width; nominal latency is WIDTH+2 cycles.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-low: 0 resets the block, 1 runs it.
start  input  1  request strobe; sampled only when busy=0.
signed_op  input  1  1 = DIV (two's complement), 0 = DIVU.
dividend  input  WIDTH  numerator; captured on accepted start.
divisor  input  WIDTH  denominator; captured on accepted start.
cancel  input  1  flush; aborts any in-flight operation.
busy  output  1  operation in progress (CALC or FIX state).
valid  output  1  one-cycle result strobe.
quotient  output  WIDTH  LO result; held until the next accepted start.
remainder  output  WIDTH  HI result; held until the next accepted start.
result  output  2*WIDTH  {remainder, quotient}, for HILO.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, busy=0, valid=0, quotient=0, remainder=0.
  - Reset mid-operation discards all work.
  - No valid pulse after rst returns high.
- States and transitions:
  - IDLE -> CALC: start=1 and cancel=0 at edge E0. The edge latches the operand magnitudes, the sign flags (neg_q = signed_op & (a[W-1]^b[W-1]); neg_r = signed_op & a[W-1]), a divisor-zero flag, and counter=0.
  - CALC: one restoring step per cycle. Shift {rem,quo} left by 1, subtract |divisor| from rem, keep the result if non-negative and set the quotient LSB. Stay in CALC for exactly WIDTH cycles (counter 0..WIDTH-1), then go to FIX.
  - FIX: apply signs; quotient = neg_q ? -q : q, remainder = neg_r ? -r : r. Go to DONE.
  - DONE: valid=1, busy=0 for exactly one cycle, then IDLE. A start in DONE is accepted (DONE -> CALC), giving back-to-back operation.
- Latency:
  - With start sampled at E0, CALC covers cycles 1..WIDTH, FIX covers cycle WIDTH+1, and valid is high in cycle WIDTH+2 (34 for the default).
  - busy is high in cycles 1..WIDTH+1.
- Handshake rules:
  - start while busy=1 is ignored; operands are not re-latched.
  - Inputs need only be stable in the start cycle.
- cancel:
  - In any state, cancel=1 forces IDLE at the next edge, with no valid pulse.
  - quotient and remainder keep their last completed values.
  - cancel and start in the same cycle: cancel wins and start is dropped.
- Arithmetic rules:
  - Magnitudes are WIDTH-bit unsigned, so |0x80000000| = 0x80000000 is exact.
  - Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Remainder sign follows the dividend.
  - Quotient truncates toward zero.
- Divide by zero (either mode): quotient = all ones, remainder = the original dividend bits. Latency is unchanged; the divisor-zero flag overrides the FIX result.
- Output registers update only on the FIX -> DONE edge.

Optional Feature:
DIV_EARLY_OUT_EN:
- Defined: at an accepted start, if divisor==0 or |dividend| < |divisor|, the block skips CALC and FIX and goes IDLE -> DONE.
  - valid is high in cycle 1 and busy is never asserted.
  - Results: divisor 0 follows the divide-by-zero rule above; otherwise quotient=0, remainder=dividend.
- Undefined: every operation takes WIDTH+2 cycles and there is no comparison logic at start.

Test Plan:
- DIVU 100 / 7 -> busy 1 in cycles 1..33; valid in cycle 34 only; quotient=14, remainder=2, result=0x00000002_0000000E.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- DIVU 0x12345678 / 0 -> quotient=0xFFFFFFFF, remainder=0x12345678, valid in cycle 34 (cycle 1 with DIV_EARLY_OUT_EN; also check 5/9 -> q=0, r=5 in cycle 1).
- Start 100/7, pulse start with 50/5 in cycle 10 -> second request ignored; result 14/2. Issue 50/5 in the DONE cycle -> q=10, r=0 valid 34 cycles later.
- Start 100/7, cancel in cycle 20 -> IDLE in cycle 21, no valid within 40 cycles, outputs keep previous values; cancel+start together in IDLE -> busy stays 0.
- Drop rst to 0 asynchronously in cycle 15 -> busy, valid, quotient and remainder go to 0 immediately; after release, no spurious valid.
